// File: rtl/alpopseq_if.sv
// Opcode-sequencer bus: the request/control inputs and the opcode/status
// outputs of alpopseq. The master modport is the sequencer itself; the slave
// modport is the requesting side (ALPCTL field logic or a testbench).
interface alpopseq_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start_h;
    logic [1:0]       op_h;
    logic [CNT_W-1:0] count_h;
    logic             mulbit_h;
    logic             stall_h;
    logic [3:0]       alu_h;
    logic             dmove_h;
    logic             pass_a_h;
    logic             busy_h;
    logic             done_h;
    logic [CNT_W-1:0] remain_h;

    modport master (
        input  start_h, op_h, count_h, mulbit_h, stall_h,
        output alu_h, dmove_h, pass_a_h, busy_h, done_h, remain_h
    );

    modport slave (
        output start_h, op_h, count_h, mulbit_h, stall_h,
        input  alu_h, dmove_h, pass_a_h, busy_h, done_h, remain_h
    );
endinterface

// File: rtl/alpopseq.sv
// ALU opcode sequencer: turns one start request into a per-clock stream of
// ALU codes for multiply, packed-decimal add/subtract and left shift.
module alpopseq #(
    parameter int unsigned CNT_W = 5
) (
    input  logic          clk_h,
    input  logic          reset_h,
    alpopseq_if.master    bus
);
    localparam logic [3:0] ALU_PLAIN   = 4'hC;
    localparam logic [3:0] ALU_SUB     = 4'h0;
    localparam logic [3:0] ALU_SUB_BCD = 4'h1;
    localparam logic [3:0] ALU_ADD_BCD = 4'h5;
    localparam logic [3:0] ALU_ADD_SR  = 4'h6;
    localparam logic [3:0] ALU_AND_SR  = 4'hA;
    localparam logic [3:0] ALU_AND_SL  = 4'hB;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_ADDP = 2'b01;
    localparam logic [1:0] OP_SUBP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic [3:0]       alu_q;
    logic             dmove_q;
    logic             busy_q;
    logic             done_q;
    logic             mul_iter;

    // Fixed per-iteration opcode for the non-multiply operations.
    function automatic logic [3:0] iter_code(input logic [1:0] op);
        case (op)
            OP_ADDP: iter_code = ALU_ADD_BCD;
            OP_SUBP: iter_code = ALU_SUB_BCD;
            OP_MUL:  iter_code = ALU_AND_SR;
            default: iter_code = ALU_AND_SL;
        endcase
    endfunction

    // Sequencer state, iteration count, sign flag and registered outputs.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state   <= S_IDLE;
            op_q    <= 2'b00;
            cnt     <= '0;
            sign    <= 1'b0;
            alu_q   <= ALU_PLAIN;
            dmove_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.stall_h) begin
            case (state)
                S_IDLE: begin
                    if (bus.start_h) begin
                        state   <= S_LOAD;
                        op_q    <= bus.op_h;
                        cnt     <= bus.count_h;
                        sign    <= 1'b0;
                        alu_q   <= ALU_PLAIN;
                        dmove_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dmove_q <= 1'b0;
                    if (cnt == '0) begin
                        state  <= S_DONE;
                        alu_q  <= ALU_PLAIN;
                        done_q <= 1'b1;
                    end else begin
                        state <= S_ITER;
                        alu_q <= iter_code(op_q);
                    end
                end
                S_ITER: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        alu_q <= ALU_PLAIN;
                        if (op_q == OP_MUL) begin
                            // Last multiplier bit is the sign: a set sign needs a subtract fix-up.
                            sign <= bus.mulbit_h;
                            if (bus.mulbit_h) begin
                                state <= S_FIX;
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    state  <= S_DONE;
                    alu_q  <= ALU_PLAIN;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    alu_q  <= ALU_PLAIN;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    alu_q   <= ALU_PLAIN;
                    dmove_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Multiply iterations pick their opcode from the live multiplier bit.
    always_comb begin
        mul_iter = (state == S_ITER) && (op_q == OP_MUL);
        if (mul_iter) begin
            bus.alu_h = bus.mulbit_h ? ALU_ADD_SR : ALU_AND_SR;
        end else if ((state == S_FIX) && sign) begin
            bus.alu_h = ALU_SUB;
        end else begin
            bus.alu_h = alu_q;
        end
    end

    assign bus.dmove_h  = dmove_q;
    assign bus.pass_a_h = 1'b0;
    assign bus.busy_h   = busy_q;
    assign bus.done_h   = done_q;
    assign bus.remain_h = cnt;
endmodule

// File: doc/alpopseq.md
# alpopseq

ALU opcode sequencer for the ALP data path. It is the issuing end of the ALU opcode interface: from a single start request it drives the 4-bit ALU code, data-move and pass-A controls that the ALP slice ALU decoders consume, one step per clock. It handles multi-cycle signed multiply, packed-decimal add/subtract and multi-bit left shift. It sits between the microsequencer/ALPCTL field logic and the ALP slices.

## Interface
Parameters:
- CNT_W, 5, width of the iteration count; maximum iterations 2^CNT_W-1.

Ports:
- clk_h  in  1  clock; all state changes on rising edge
- reset_h  in  1  asynchronous, active-high reset
- start_h  in  1  request; sampled only in IDLE
- op_h  in  2  operation: 00 MUL (signed shift-add), 01 ADDP, 10 SUBP, 11 SHL
- count_h  in  CNT_W  iteration count; sampled with start_h
- mulbit_h  in  1  current multiplier LSB from Q register; used in MUL ITER only
- stall_h  in  1  freeze: hold state, count and all outputs
- alu_h  out  4  ALU opcode to slices
- dmove_h  out  1  data-move (A->W) request
- pass_a_h  out  1  pass-A qualifier
- busy_h  out  1  high in any state except IDLE
- done_h  out  1  one-cycle completion pulse
- remain_h  out  CNT_W  iterations still to issue

## Operation
Opcode constants used: IDLE/plain 4'hC, SUB 4'h0, SUB_BCD 4'h1, ADD_BCD 4'h5, ADD_SR 4'h6, ADD_SL 4'h7, AND_SR 4'hA, AND_SL 4'hB.
States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: alu_h=4'hC, dmove_h=0, pass_a_h=0, busy_h=0, done_h=0. start_h=1 -> LOAD; latch op_h, count_h into op/cnt registers; clear sign flag.
- LOAD: one cycle; dmove_h=1, alu_h=4'hC. cnt==0 -> DONE; else -> ITER.
- ITER: one opcode per cycle, cnt decrements each non-stalled cycle; when cnt reaches 1 and decrements -> FIX (MUL) or DONE (others).
  - MUL: mulbit_h=1 -> alu_h=4'h6 (ADD_SR); mulbit_h=0 -> alu_h=4'hA (AND_SR), pass_a_h=0. alu_h is combinational on mulbit_h (Mealy); mulbit_h in the final ITER cycle is registered as sign flag.
  - ADDP: alu_h=4'h5. SUBP: alu_h=4'h1. SHL: alu_h=4'hB.
- FIX (MUL only): sign flag=1 -> alu_h=4'h0 (SUB correction), one cycle; sign flag=0 -> FIX is skipped (final ITER goes straight to DONE).
- DONE: done_h=1, alu_h=4'hC, one cycle -> IDLE.
- remain_h = cnt register; 0 in IDLE.
- start_h while busy_h=1: ignored, no queueing.
- stall_h=1: no state, cnt or sign-flag update; outputs frozen at their registered values. During a MUL ITER stall, alu_h still follows mulbit_h. done_h stays high for the whole stalled DONE cycle and pulses only once in total.
- op_h/count_h changes after LOAD have no effect.

## Timing
- Reset (async, any state, mid-operation included): state=IDLE, cnt=0, sign=0; alu_h=4'hC, dmove_h=0, pass_a_h=0, busy_h=0, done_h=0, remain_h=0. Operation is abandoned, with no done_h pulse.
- start_h sampled at edge E0 -> LOAD during cycle E0..E1; ITER cycles E1..E(N+1).
- F = 1 if MUL and sign flag set, else 0. DONE during cycle E(N+1+F)..E(N+2+F).
- Start-to-done latency: N+2+F cycles without stalls; each stall cycle adds one.
- N=0: LOAD -> DONE, latency 2 cycles; FIX never entered.
- Back-to-back: start_h in the cycle after DONE (IDLE) is accepted; start_h during DONE is ignored.

## Test plan
- Reset during ITER of MUL N=8 at step 3 -> all outputs at reset values next cycle; IDLE, no done_h; a following start is accepted.
- MUL, N=4, mulbit_h sequence 1,0,1,0 -> alu_h 6,A,6,A on cycles 2-5; no FIX; done_h in cycle 6.
- MUL, N=3, mulbit_h 0,1,1 -> alu_h A,6,6; FIX alu_h=0; done_h in cycle 6; remain_h 3,2,1 during ITER.
- ADDP N=2 with stall_h high for 2 cycles mid-ITER -> alu_h=5 held; remain_h frozen; done_h delayed 2 cycles to cycle 6, single pulse.
- SHL N=0 -> LOAD (dmove_h=1) then DONE; alu_h never 4'hB; latency 2.
- SUBP N=3 with start_h held high throughout -> alu_h=1 for 3 cycles; ignored while busy; new operation starts on the first IDLE cycle after done_h.
